// File: rtl/s27_array.sv
// s27_array: CHANNELS independent s27 cores sharing clock, reset and clock enable,
// with an OUT_STAGES-deep output pipeline on G17 and a state observation port.
// Define S27_SCAN_EN to add a scan chain (SE/SI/SO) through every state flop.
module s27_array #(
  parameter int CHANNELS   = 4,
  parameter int OUT_STAGES = 1
) (
  input  logic                  CK,
  input  logic                  RN,
  input  logic                  CE,
  input  logic [CHANNELS-1:0]   G0,
  input  logic [CHANNELS-1:0]   G1,
  input  logic [CHANNELS-1:0]   G2,
  input  logic [CHANNELS-1:0]   G3,
  output logic [CHANNELS-1:0]   G17,
  output logic [3*CHANNELS-1:0] STATE
`ifdef S27_SCAN_EN
  ,
  input  logic                  SE,
  input  logic                  SI,
  output logic                  SO
`endif
);

  localparam int NS = 3 * CHANNELS;

  logic [NS-1:0]       state_q;
  logic [NS-1:0]       state_d;
  logic [NS-1:0]       func_next_s;
  logic                pipe_en_s;

  logic [CHANNELS-1:0] g5_s;
  logic [CHANNELS-1:0] g6_s;
  logic [CHANNELS-1:0] g7_s;
  logic [CHANNELS-1:0] g8_s;
  logic [CHANNELS-1:0] g9_s;
  logic [CHANNELS-1:0] g10_s;
  logic [CHANNELS-1:0] g11_s;
  logic [CHANNELS-1:0] g12_s;
  logic [CHANNELS-1:0] g13_s;
  logic [CHANNELS-1:0] g14_s;
  logic [CHANNELS-1:0] g15_s;
  logic [CHANNELS-1:0] g16_s;
  logic [CHANNELS-1:0] g17c_s;

  // Core i keeps {G7,G6,G5} at [3i+2:3i]; this order is also the scan order.
  for (genvar i = 0; i < CHANNELS; i++) begin : g_core_map
    assign g5_s[i]            = state_q[3*i];
    assign g6_s[i]            = state_q[3*i+1];
    assign g7_s[i]            = state_q[3*i+2];
    assign func_next_s[3*i]   = g10_s[i];
    assign func_next_s[3*i+1] = g11_s[i];
    assign func_next_s[3*i+2] = g13_s[i];
  end

  // The s27 netlist is purely bitwise, so every core is evaluated in parallel.
  assign g14_s  = ~G0;
  assign g8_s   = g14_s & g6_s;
  assign g12_s  = ~(G1 | g7_s);
  assign g15_s  = g12_s | g8_s;
  assign g16_s  = G3 | g8_s;
  assign g9_s   = ~(g16_s & g15_s);
  assign g11_s  = ~(g5_s | g9_s);
  assign g10_s  = ~(g14_s | g11_s);
  assign g13_s  = ~(G2 | g12_s);
  assign g17c_s = ~g11_s;

  // Next-state selection: scan shift, functional update, or hold.
  always_comb begin
    state_d   = state_q;
    pipe_en_s = 1'b0;
`ifdef S27_SCAN_EN
    if (SE) begin
      state_d   = {state_q[NS-2:0], SI};
      pipe_en_s = 1'b0;
    end else if (CE) begin
      state_d   = func_next_s;
      pipe_en_s = 1'b1;
    end else begin
      state_d   = state_q;
      pipe_en_s = 1'b0;
    end
`else
    if (CE) begin
      state_d   = func_next_s;
      pipe_en_s = 1'b1;
    end else begin
      state_d   = state_q;
      pipe_en_s = 1'b0;
    end
`endif
  end

  // State flops of all cores.
  always_ff @(posedge CK or negedge RN) begin
    if (!RN) begin
      state_q <= '0;
    end else begin
      state_q <= state_d;
    end
  end

  assign STATE = state_q;

`ifdef S27_SCAN_EN
  assign SO = state_q[NS-1];
`endif

  if (OUT_STAGES == 0) begin : g_comb_out
    assign G17 = g17c_s;
  end else begin : g_pipe_out
    logic [OUT_STAGES-1:0][CHANNELS-1:0] pipe_q;
    logic [OUT_STAGES-1:0][CHANNELS-1:0] pipe_d;

    // Output pipeline advances only on enabled functional cycles.
    always_comb begin
      pipe_d = pipe_q;
      if (pipe_en_s) begin
        pipe_d[0] = g17c_s;
        for (int k = 1; k < OUT_STAGES; k++) begin
          pipe_d[k] = pipe_q[k-1];
        end
      end else begin
        pipe_d = pipe_q;
      end
    end

    // Output pipeline flops.
    always_ff @(posedge CK or negedge RN) begin
      if (!RN) begin
        pipe_q <= '0;
      end else begin
        pipe_q <= pipe_d;
      end
    end

    assign G17 = pipe_q[OUT_STAGES-1];
  end

endmodule

// File: tb/tb_s27_array.sv
// Directed self-checking bench for s27_array (CHANNELS=4, OUT_STAGES=1).
// Scan-chain scenario is included when S27_SCAN_EN is defined.
module tb_s27_array;

  logic        CK;
  logic        RN;
  logic        CE;
  logic [3:0]  G0;
  logic [3:0]  G1;
  logic [3:0]  G2;
  logic [3:0]  G3;
  logic [3:0]  G17;
  logic [11:0] STATE;
`ifdef S27_SCAN_EN
  logic        SE;
  logic        SI;
  logic        SO;
`endif

  int n_checks;
  int n_fail;

  s27_array #(.CHANNELS(4), .OUT_STAGES(1)) dut (
    .CK    (CK),
    .RN    (RN),
    .CE    (CE),
    .G0    (G0),
    .G1    (G1),
    .G2    (G2),
    .G3    (G3),
    .G17   (G17),
    .STATE (STATE)
`ifdef S27_SCAN_EN
    ,
    .SE    (SE),
    .SI    (SI),
    .SO    (SO)
`endif
  );

  initial CK = 1'b0;
  always #5 CK = ~CK;

  task automatic tick();
    @(posedge CK);
    #1;
  endtask

  task automatic do_reset();
    G0 = 4'h0; G1 = 4'h0; G2 = 4'h0; G3 = 4'h0;
    CE = 1'b1;
    RN = 1'b0;
    #1;
    RN = 1'b1;
  endtask

  task automatic test_reset();
    RN = 1'b0; CE = 1'b1;
    G0 = 4'hA; G1 = 4'h5; G2 = 4'hF; G3 = 4'h3;
    tick(); tick();
    n_checks++;
    if (STATE !== 12'h000) begin n_fail++; $display("FAIL reset_state got=%h exp=%h", STATE, 12'h000); end
    n_checks++;
    if (G17 !== 4'h0) begin n_fail++; $display("FAIL reset_g17 got=%h exp=%h", G17, 4'h0); end
    G0 = 4'h0; G1 = 4'h0; G2 = 4'h0; G3 = 4'h0;
    RN = 1'b1;
    #1;
    n_checks++;
    if (G17 !== 4'h0) begin n_fail++; $display("FAIL release_g17_pre got=%h exp=%h", G17, 4'h0); end
    tick();
    n_checks++;
    if (STATE !== 12'h000) begin n_fail++; $display("FAIL release_state got=%h exp=%h", STATE, 12'h000); end
    n_checks++;
    if (G17 !== 4'hF) begin n_fail++; $display("FAIL release_g17 got=%h exp=%h", G17, 4'hF); end
    tick();
    n_checks++;
    if (STATE !== 12'h000) begin n_fail++; $display("FAIL idle_state got=%h exp=%h", STATE, 12'h000); end
  endtask

  task automatic test_ch0_101();
    do_reset();
    G0 = 4'b0001; G1 = 4'b0001; G2 = 4'b0000; G3 = 4'b0001;
    tick();
    n_checks++;
    if (STATE !== 12'h005) begin n_fail++; $display("FAIL ch0_101_state got=%h exp=%h", STATE, 12'h005); end
    n_checks++;
    if (G17 !== 4'hF) begin n_fail++; $display("FAIL ch0_101_g17 got=%h exp=%h", G17, 4'hF); end
    tick();
    n_checks++;
    if (STATE !== 12'h005) begin n_fail++; $display("FAIL ch0_101_hold_state got=%h exp=%h", STATE, 12'h005); end
    n_checks++;
    if (G17 !== 4'hF) begin n_fail++; $display("FAIL ch0_101_hold_g17 got=%h exp=%h", G17, 4'hF); end
  endtask

  task automatic test_ch0_010();
    do_reset();
    G0 = 4'b0001; G1 = 4'b0000; G2 = 4'b0000; G3 = 4'b0001;
    tick();
    n_checks++;
    if (STATE !== 12'h002) begin n_fail++; $display("FAIL ch0_010_state got=%h exp=%h", STATE, 12'h002); end
    n_checks++;
    if (G17 !== 4'hE) begin n_fail++; $display("FAIL ch0_010_g17 got=%h exp=%h", G17, 4'hE); end
    G0 = 4'b0000; G1 = 4'b0000;
    tick();
    n_checks++;
    if (STATE !== 12'h002) begin n_fail++; $display("FAIL ch0_010_hold_state got=%h exp=%h", STATE, 12'h002); end
    n_checks++;
    if (G17 !== 4'hE) begin n_fail++; $display("FAIL ch0_010_hold_g17 got=%h exp=%h", G17, 4'hE); end
  endtask

  task automatic test_independence();
    do_reset();
    G0 = 4'b0011; G1 = 4'b0001; G2 = 4'b0000; G3 = 4'b0011;
    tick();
    n_checks++;
    if (STATE !== 12'h015) begin n_fail++; $display("FAIL indep_state got=%h exp=%h", STATE, 12'h015); end
    n_checks++;
    if (G17 !== 4'hD) begin n_fail++; $display("FAIL indep_g17 got=%h exp=%h", G17, 4'hD); end
    G0 = 4'b0001; G1 = 4'b0001; G2 = 4'b0000; G3 = 4'b0011;
    tick();
    n_checks++;
    if (STATE !== 12'h015) begin n_fail++; $display("FAIL indep_hold_state got=%h exp=%h", STATE, 12'h015); end
    n_checks++;
    if (G17 !== 4'hD) begin n_fail++; $display("FAIL indep_hold_g17 got=%h exp=%h", G17, 4'hD); end
  endtask

  task automatic test_ce_hold();
    logic [3:0] pat [3];
    pat[0] = 4'hF; pat[1] = 4'h6; pat[2] = 4'h9;
    CE = 1'b0;
    for (int k = 0; k < 3; k++) begin
      G0 = pat[k]; G1 = ~pat[k]; G2 = pat[k]; G3 = 4'hF;
      tick();
      n_checks++;
      if (STATE !== 12'h015) begin n_fail++; $display("FAIL ce_hold_state[%0d] got=%h exp=%h", k, STATE, 12'h015); end
      n_checks++;
      if (G17 !== 4'hD) begin n_fail++; $display("FAIL ce_hold_g17[%0d] got=%h exp=%h", k, G17, 4'hD); end
    end
    RN = 1'b0;
    #1;
    n_checks++;
    if (STATE !== 12'h000) begin n_fail++; $display("FAIL midhold_reset_state got=%h exp=%h", STATE, 12'h000); end
    n_checks++;
    if (G17 !== 4'h0) begin n_fail++; $display("FAIL midhold_reset_g17 got=%h exp=%h", G17, 4'h0); end
    tick();
    n_checks++;
    if (STATE !== 12'h000) begin n_fail++; $display("FAIL reset_over_ce_state got=%h exp=%h", STATE, 12'h000); end
    RN = 1'b1;
    CE = 1'b1;
  endtask

`ifdef S27_SCAN_EN
  task automatic test_scan();
    logic [11:0] prior;
    SE = 1'b0; SI = 1'b0;
    do_reset();
    G0 = 4'b0011; G1 = 4'b0001; G2 = 4'b0000; G3 = 4'b0011;
    tick();
    prior = 12'h015;
    SE = 1'b1;
    for (int k = 0; k < 12; k++) begin
      SI = (k % 2 == 0) ? 1'b1 : 1'b0;
      n_checks++;
      if (SO !== prior[11-k]) begin n_fail++; $display("FAIL scan_so[%0d] got=%b exp=%b", k, SO, prior[11-k]); end
      tick();
    end
    n_checks++;
    if (STATE !== 12'hAAA) begin n_fail++; $display("FAIL scan_load_state got=%h exp=%h", STATE, 12'hAAA); end
    n_checks++;
    if (G17 !== 4'hD) begin n_fail++; $display("FAIL scan_pipe_hold got=%h exp=%h", G17, 4'hD); end
    SE = 1'b0;
    G0 = 4'h0; G1 = 4'h0; G2 = 4'h0; G3 = 4'h0;
    tick();
    n_checks++;
    if (STATE !== 12'h8A2) begin n_fail++; $display("FAIL scan_resume_state got=%h exp=%h", STATE, 12'h8A2); end
    n_checks++;
    if (G17 !== 4'hA) begin n_fail++; $display("FAIL scan_resume_g17 got=%h exp=%h", G17, 4'hA); end
  endtask
`endif

  initial begin
    n_checks = 0;
    n_fail   = 0;
    RN = 1'b0; CE = 1'b0;
    G0 = 4'h0; G1 = 4'h0; G2 = 4'h0; G3 = 4'h0;
`ifdef S27_SCAN_EN
    SE = 1'b0; SI = 1'b0;
`endif
    test_reset();
    test_ch0_101();
    test_ch0_010();
    test_independence();
    test_ce_hold();
`ifdef S27_SCAN_EN
    test_scan();
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
